m6502_bus_ctrl: RTL and testbench

Memory bus controller sitting directly downstream of the m6502 CPU core. It accepts the CPU's single-cycle read/write requests, decodes the address into RAM, IO and ROM regions, and drives a synchronous memory port with configurable latency. It returns read data and the `ready` handshake the CPU uses to stall. It also flags protocol violations for debug.

---
 rtl/m6502_bus_ctrl.sv | 152 +++++++++++++++
 tb/tb_m6502_bus_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m6502_bus_ctrl.sv
// Bus controller between the m6502 core and a synchronous memory port: decodes RAM/IO/ROM,
// times each access with a down-counter and holds cpu_ready low until the access completes.
module m6502_bus_ctrl #(
    parameter int          RD_LATENCY = 1,
    parameter int          WR_WAIT    = 1,
    parameter logic [15:0] IO_BASE    = 16'hD000,
    parameter logic [15:0] ROM_BASE   = 16'hE000,
    parameter int          IO_WAIT    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd_req,
    input  logic        cpu_wr_en,
    input  logic [7:0]  cpu_wr_data,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic [1:0]  mem_region,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] REG_RAM = 2'd0;
    localparam logic [1:0] REG_IO  = 2'd1;
    localparam logic [1:0] REG_ROM = 2'd2;

    localparam logic [3:0] RD_CNT = 4'(RD_LATENCY);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);
    localparam logic [3:0] IO_CNT = 4'(IO_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_en_q, mem_rd_en_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [7:0]  mem_wr_data_q, mem_wr_data_d;
    logic [1:0]  mem_region_q, mem_region_d;
    logic [7:0]  cpu_rd_data_q, cpu_rd_data_d;
    logic        bus_err_q, bus_err_d;

    logic [1:0]  region;
    logic [3:0]  io_extra;

    always_comb begin
        region = REG_RAM;
        if (cpu_addr >= ROM_BASE) begin
            region = REG_ROM;
        end else if (cpu_addr >= IO_BASE) begin
            region = REG_IO;
        end
        io_extra = (region == REG_IO) ? IO_CNT : 4'd0;
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_en_d   = 1'b0;
        mem_wr_en_d   = 1'b0;
        mem_wr_data_d = mem_wr_data_q;
        mem_region_d  = mem_region_q;
        cpu_rd_data_d = cpu_rd_data_q;
        bus_err_d     = bus_err_q;

        case (state_q)
            IDLE: begin
                if (cpu_wr_en) begin
                    mem_addr_d    = cpu_addr;
                    mem_wr_data_d = cpu_wr_data;
                    mem_region_d  = region;
                    // ROM writes still take the full handshake, only the strobe is dropped
                    mem_wr_en_d   = (region != REG_ROM);
                    wait_cnt_d    = WR_CNT + io_extra;
                    state_d       = WRITE;
                    if (cpu_rd_req) begin
                        bus_err_d = 1'b1;
                    end
                end else if (cpu_rd_req) begin
                    mem_addr_d   = cpu_addr;
                    mem_region_d = region;
                    mem_rd_en_d  = 1'b1;
                    wait_cnt_d   = RD_CNT + io_extra;
                    state_d      = READ;
                end
            end
            READ: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    cpu_rd_data_d = mem_rd_data;
                    state_d       = IDLE;
                end
            end
            WRITE: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && (cpu_rd_req || cpu_wr_en)) begin
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 4'd0;
            mem_addr_q    <= 16'h0000;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= 8'h00;
            mem_region_q  <= REG_RAM;
            cpu_rd_data_q <= 8'h00;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_region_q  <= mem_region_d;
            cpu_rd_data_q <= cpu_rd_data_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign cpu_ready   = (state_q == IDLE);
    assign cpu_rd_data = cpu_rd_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_data = mem_wr_data_q;
    assign mem_region  = mem_region_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_m6502_bus_ctrl.sv
// Scoreboard bench for m6502_bus_ctrl: stimulus pushes expected strobes and completions,
// a monitor pops and compares them as the DUT presents them.
module tb_m6502_bus_ctrl;

    localparam int          RD_LATENCY = 1;
    localparam int          WR_WAIT    = 1;
    localparam int          IO_WAIT    = 2;
    localparam logic [15:0] IO_BASE    = 16'hD000;
    localparam logic [15:0] ROM_BASE   = 16'hE000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rd_req = 1'b0;
    logic        cpu_wr_en = 1'b0;
    logic [7:0]  cpu_wr_data = 8'h00;
    logic [7:0]  cpu_rd_data;
    logic        cpu_ready;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;
    logic [1:0]  mem_region;
    logic        bus_err;

    always #5 clk = ~clk;

    m6502_bus_ctrl #(
        .RD_LATENCY(RD_LATENCY),
        .WR_WAIT   (WR_WAIT),
        .IO_BASE   (IO_BASE),
        .ROM_BASE  (ROM_BASE),
        .IO_WAIT   (IO_WAIT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_rd_req (cpu_rd_req),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_ready  (cpu_ready),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .mem_region (mem_region),
        .bus_err    (bus_err)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [1:0]  region;
    } strobe_t;

    typedef struct packed {
        logic [7:0] rd_data;
        logic [7:0] busy;
        logic       err;
    } done_t;

    strobe_t    sq[$];
    done_t      dq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_mem [65536];
    logic [7:0] last_rd;
    logic       err_model;
    logic [15:0] bnd [6];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h0200: return 8'hA5;
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'hE0;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5B;
        endcase
    endfunction

    function automatic logic [1:0] exp_region(input logic [15:0] a);
        if (a >= ROM_BASE) return 2'd2;
        if (a >= IO_BASE)  return 2'd1;
        return 2'd0;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Memory behind the port: filled on the first edge, updated only by real write strobes.
    logic [7:0] bench_mem [65536];
    bit         mem_filled = 1'b0;
    always @(posedge clk) begin
        if (!mem_filled) begin
            for (int i = 0; i < 65536; i++) bench_mem[i] = init_val(16'(i));
            mem_filled = 1'b1;
        end else if (mem_wr_en) begin
            bench_mem[mem_addr] = mem_wr_data;
        end
    end
    assign mem_rd_data = bench_mem[mem_addr];

    initial begin : monitor
        int      busy;
        strobe_t s;
        done_t   d;
        busy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                busy = 0;
            end else begin
                if (mem_rd_en || mem_wr_en) begin
                    if (sq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_strobe: rd_en=%0b wr_en=%0b addr=%h, required no strobe",
                                 mem_rd_en, mem_wr_en, mem_addr);
                    end else begin
                        s = sq.pop_front();
                        chk("strobe_kind", 32'({mem_wr_en, mem_rd_en}), s.wr ? 32'd2 : 32'd1);
                        chk("mem_addr", 32'(mem_addr), 32'(s.addr));
                        chk("mem_region", 32'(mem_region), 32'(s.region));
                        if (s.wr) chk("mem_wr_data", 32'(mem_wr_data), 32'(s.data));
                    end
                end
                if (!cpu_ready) begin
                    busy++;
                end else if (busy > 0) begin
                    if (dq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_completion: busy=%0d, required no completion", busy);
                    end else begin
                        d = dq.pop_front();
                        chk("ready_low_cycles", 32'(busy), 32'(d.busy));
                        chk("cpu_rd_data", 32'(cpu_rd_data), 32'(d.rd_data));
                        chk("bus_err", 32'(bus_err), 32'(d.err));
                    end
                    busy = 0;
                end
            end
        end
    end

    // Called just after a falling edge; returns at a falling edge with cpu_ready high.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [7:0] d, input bit inject);
        logic [1:0] rg;
        int         n;
        int         guard;
        strobe_t    s;
        done_t      e;
        rg = exp_region(a);
        if (wr) begin
            n = WR_WAIT + ((rg == 2'd1) ? IO_WAIT : 0);
            if (rd) err_model = 1'b1;
            if (rg != 2'd2) begin
                s = '{wr: 1'b1, addr: a, data: d, region: rg};
                sq.push_back(s);
                model_mem[a] = d;
            end
        end else begin
            n = RD_LATENCY + ((rg == 2'd1) ? IO_WAIT : 0);
            s = '{wr: 1'b0, addr: a, data: 8'h00, region: rg};
            sq.push_back(s);
            last_rd = model_mem[a];
        end
        if (inject && n >= 2) err_model = 1'b1;
        e = '{rd_data: last_rd, busy: 8'(n), err: err_model};
        dq.push_back(e);

        cpu_addr = a; cpu_rd_req = rd; cpu_wr_en = wr; cpu_wr_data = d;
        @(negedge clk);
        cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
        chk("accepted_ready_low", 32'(cpu_ready), 32'd0);
        if (inject && n >= 2) begin
            cpu_addr    = 16'($urandom);
            cpu_wr_data = 8'($urandom);
            cpu_wr_en   = ($urandom_range(0, 1) == 1);
            cpu_rd_req  = !cpu_wr_en;
            @(negedge clk);
            cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
        end
        guard = 0;
        while (!cpu_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!cpu_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: cpu_ready=%0b after %0d cycles, required 1", cpu_ready, guard);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bnd = '{IO_BASE - 16'd1, IO_BASE, ROM_BASE - 16'd1, ROM_BASE, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 65536; i++) model_mem[i] = init_val(16'(i));
        last_rd   = 8'h00;
        err_model = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("rst_cpu_rd_data", 32'(cpu_rd_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
        chk("rst_mem_region", 32'(mem_region), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        reset_n = 1'b1;

        issue(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0);
        issue(1'b1, 1'b0, 16'hD010, 8'h00, 1'b0);
        issue(1'b1, 1'b0, 16'hCFFF, 8'h00, 1'b0);
        issue(1'b0, 1'b1, 16'h0400, 8'h3C, 1'b0);
        issue(1'b0, 1'b1, 16'hFFFC, 8'h3C, 1'b0);
        issue(1'b1, 1'b0, 16'h0400, 8'h00, 1'b0);
        issue(1'b1, 1'b0, 16'hD010, 8'h00, 1'b1);
        issue(1'b1, 1'b1, 16'h0401, 8'h77, 1'b0);
        issue(1'b1, 1'b0, 16'h0401, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset one cycle into an IO read: the strobe happens, the completion never does.
        sq.push_back('{wr: 1'b0, addr: 16'hD020, data: 8'h00, region: 2'd1});
        cpu_addr = 16'hD020; cpu_rd_req = 1'b1;
        @(negedge clk);
        cpu_rd_req = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("midrst_cpu_rd_data", 32'(cpu_rd_data), 32'd0);
        chk("midrst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("midrst_bus_err", 32'(bus_err), 32'd0);
        reset_n   = 1'b1;
        last_rd   = 8'h00;
        err_model = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_late_capture", 32'(cpu_rd_data), 32'd0);
        chk("idle_after_reset", 32'(cpu_ready), 32'd1);

        // Reset vector fetch, second read issued on the first ready cycle.
        issue(1'b1, 1'b0, 16'hFFFC, 8'h00, 1'b0);
        issue(1'b1, 1'b0, 16'hFFFD, 8'h00, 1'b0);

        for (int i = 0; i < 250; i++) begin
            logic [15:0] a;
            logic        rd;
            logic        wr;
            bit          inj;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case ($urandom_range(0, 3))
                0:       a = bnd[$urandom_range(0, 5)];
                1:       a = 16'h0400 + 16'($urandom_range(0, 3));
                2:       a = 16'hD000 + 16'($urandom_range(0, 15));
                default: a = 16'($urandom);
            endcase
            wr  = ($urandom_range(0, 1) == 1);
            rd  = !wr || ($urandom_range(0, 15) == 0);
            inj = ($urandom_range(0, 9) == 0);
            issue(rd, wr, a, 8'($urandom), inj);
        end

        repeat (3) @(negedge clk);
        chk("strobe_queue_drained", 32'(sq.size()), 32'd0);
        chk("done_queue_drained", 32'(dq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
